// File: rtl/greenhouse_pkg.sv
// Shared constants and types for the greenhouse telemetry framer:
// frame geometry, byte positions, FSM encoding and status-byte layout.
package greenhouse_pkg;

  localparam int FRAME_LEN = 14;
  localparam int NUM_SENS  = 9;

  typedef logic [3:0] idx_t;

  localparam idx_t IDX_SYNC   = 4'd0;
  localparam idx_t IDX_SEQ    = 4'd1;
  localparam idx_t IDX_SENS0  = 4'd2;
  localparam idx_t IDX_STATUS = 4'd11;
  localparam idx_t IDX_GROWTH = 4'd12;
  localparam idx_t IDX_CSUM   = idx_t'(FRAME_LEN - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_e;

  localparam int STAT_FAN   = 0;
  localparam int STAT_IRR   = 1;
  localparam int STAT_HC    = 2;
  localparam int STAT_ALERT = 3;

  // Two's-complement of the running byte sum makes bytes 1..13 sum to zero.
  function automatic logic [7:0] csum_of(input logic [7:0] sum);
    return 8'd0 - sum;
  endfunction

endpackage

// File: rtl/greenhouse_telemetry_tx_if.sv
// Byte-wide valid/ready stream carrying telemetry frames to the link.
interface greenhouse_telemetry_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/gh_period_timer.sv
// Free-running 0..PERIOD-1 counter; tick is high in the PERIOD-1 cycle.
// PERIOD of 0 parks the counter and never ticks.
module gh_period_timer #(
  parameter int PERIOD = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = (PERIOD > 1) ? CW'(PERIOD - 1) : '0;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || PERIOD == 0 || cnt == LAST) cnt <= '0;
    else                                   cnt <= cnt + CW'(1);
  end

  assign tick = (PERIOD != 0) && (cnt == LAST);

endmodule

// File: rtl/greenhouse_telemetry_tx.sv
// Telemetry framer: snapshots sensors/status on a request or periodic tick
// and streams a 14-byte checksummed frame over a valid/ready byte port.
module greenhouse_telemetry_tx
  import greenhouse_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         PERIOD    = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_req,
  input  logic [7:0] temperature,
  input  logic [7:0] humidity,
  input  logic [7:0] soil_moisture,
  input  logic [7:0] co2_level,
  input  logic [7:0] light_intensity,
  input  logic [7:0] pressure,
  input  logic [7:0] ph_level,
  input  logic [7:0] pest_level,
  input  logic [7:0] leaf_color,
  input  logic       fan,
  input  logic       irrigation,
  input  logic       humidity_control,
  input  logic       alert,
  input  logic [7:0] growth_status,
  greenhouse_telemetry_tx_if.master tx,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frame_seq,
  output logic [7:0] overrun_cnt
);

  localparam logic [0:0] ST_IDLE = 1'(S_IDLE);
  localparam logic [0:0] ST_SEND = 1'(S_SEND);

  logic [0:0] state;
  idx_t       idx, nxt_idx;
  logic       tick, trigger, hs, last_hs;

  logic [NUM_SENS-1:0][7:0] live_sens, snap_sens;
  logic [3:0]               live_stat, snap_stat;
  logic [7:0]               snap_growth;
  logic [7:0]               csum_acc, csum, nxt_byte;
  logic [7:0]               tx_data_q;
  logic                     tx_valid_q;

  gh_period_timer #(.PERIOD(PERIOD)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Element 0 is temperature, matching frame byte IDX_SENS0.
  assign live_sens = {leaf_color, pest_level, ph_level, pressure, light_intensity,
                      co2_level, soil_moisture, humidity, temperature};

  always_comb begin
    live_stat             = '0;
    live_stat[STAT_FAN]   = fan;
    live_stat[STAT_IRR]   = irrigation;
    live_stat[STAT_HC]    = humidity_control;
    live_stat[STAT_ALERT] = alert;
  end

  assign trigger = sample_req | tick;
  assign hs      = tx_valid_q & tx.tx_ready;
  assign last_hs = hs && (idx == IDX_CSUM);

  // Checksum covers seq and the snapshot only, so live inputs cannot leak in.
  always_comb begin
    csum_acc = frame_seq + {4'b0, snap_stat} + snap_growth;
    for (int i = 0; i < NUM_SENS; i++) csum_acc = csum_acc + snap_sens[i];
    csum = csum_of(csum_acc);
  end

  // Byte for the slot after the one currently presented.
  always_comb begin
    nxt_idx  = idx + 4'd1;
    nxt_byte = 8'h00;
    case (nxt_idx)
      IDX_SYNC:   nxt_byte = SYNC_BYTE;
      IDX_SEQ:    nxt_byte = frame_seq;
      IDX_STATUS: nxt_byte = {4'b0, snap_stat};
      IDX_GROWTH: nxt_byte = snap_growth;
      IDX_CSUM:   nxt_byte = csum;
      default:
        if (nxt_idx >= IDX_SENS0 && nxt_idx < IDX_STATUS)
          nxt_byte = snap_sens[nxt_idx - IDX_SENS0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= IDX_SYNC;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      frame_done  <= 1'b0;
      frame_seq   <= '0;
      overrun_cnt <= '0;
      snap_sens   <= '0;
      snap_stat   <= '0;
      snap_growth <= '0;
    end else begin
      frame_done <= 1'b0;
      if (state == ST_IDLE) begin
        if (trigger) begin
          snap_sens   <= live_sens;
          snap_stat   <= live_stat;
          snap_growth <= growth_status;
          state       <= ST_SEND;
          idx         <= IDX_SYNC;
          tx_valid_q  <= 1'b1;
          tx_data_q   <= SYNC_BYTE;
        end
      end else begin
        // Any trigger seen while a frame is in flight, including its last
        // handshake cycle, is lost and only counted.
        if (trigger && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
        if (last_hs) begin
          state      <= ST_IDLE;
          tx_valid_q <= 1'b0;
          frame_done <= 1'b1;
          frame_seq  <= frame_seq + 8'd1;
        end else if (hs) begin
          idx       <= nxt_idx;
          tx_data_q <= nxt_byte;
        end
      end
    end
  end

  assign busy        = (state == ST_SEND);
  assign tx.tx_valid = tx_valid_q;
  assign tx.tx_data  = tx_data_q;

endmodule

// File: tb/tb_greenhouse_telemetry_tx.sv
// Randomized self-checking bench: frame-level reference model for a
// request-only instance, plus a periodic-trigger instance with PERIOD=50.
module tb_greenhouse_telemetry_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1, rst_b = 1'b1;
  logic       sample_req = 1'b0, sample_req_b = 1'b0;
  logic [7:0] sens [9];
  logic       fan, irr, hc, alert;
  logic [7:0] growth;
  logic       busy_a, done_a, busy_b, done_b;
  logic [7:0] seq_a, ovr_a, seq_b, ovr_b;

  logic [7:0] ns [9];
  logic [3:0] nst;
  logic [7:0] ngr;

  greenhouse_telemetry_tx_if txa ();
  greenhouse_telemetry_tx_if txb ();

  always #5 clk = ~clk;

  greenhouse_telemetry_tx #(.SYNC_BYTE(8'hA5), .PERIOD(0)) dut_a (
    .clk(clk), .rst(rst), .sample_req(sample_req),
    .temperature(sens[0]), .humidity(sens[1]), .soil_moisture(sens[2]),
    .co2_level(sens[3]), .light_intensity(sens[4]), .pressure(sens[5]),
    .ph_level(sens[6]), .pest_level(sens[7]), .leaf_color(sens[8]),
    .fan(fan), .irrigation(irr), .humidity_control(hc), .alert(alert),
    .growth_status(growth), .tx(txa.master),
    .busy(busy_a), .frame_done(done_a), .frame_seq(seq_a), .overrun_cnt(ovr_a)
  );

  greenhouse_telemetry_tx #(.SYNC_BYTE(8'hA5), .PERIOD(50)) dut_b (
    .clk(clk), .rst(rst_b), .sample_req(sample_req_b),
    .temperature(sens[0]), .humidity(sens[1]), .soil_moisture(sens[2]),
    .co2_level(sens[3]), .light_intensity(sens[4]), .pressure(sens[5]),
    .ph_level(sens[6]), .pest_level(sens[7]), .leaf_color(sens[8]),
    .fan(fan), .irrigation(irr), .humidity_control(hc), .alert(alert),
    .growth_status(growth), .tx(txb.master),
    .busy(busy_b), .frame_done(done_b), .frame_seq(seq_b), .overrun_cnt(ovr_b)
  );

  int n_chk = 0, n_err = 0;

  // Reference model state: the frame being sent and the position within it.
  int m_frame [14];
  int m_pos = 0, m_seq = 0, m_ovr = 0;
  bit m_busy = 0, m_done = 0, m_dz = 1;
  int got [$];
  int g1 [14], g2 [14], g3 [14];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h @%0t", tag, act, exp, $time);
    end
  endtask

  function automatic void build();
    int s = 0;
    m_frame[0] = 8'hA5;
    m_frame[1] = m_seq;
    for (int i = 0; i < 9; i++) m_frame[2+i] = sens[i];
    m_frame[11] = fan + 2*irr + 4*hc + 8*alert;
    m_frame[12] = growth;
    for (int i = 1; i < 13; i++) s += m_frame[i];
    m_frame[13] = (256 - s % 256) % 256;
  endfunction

  function automatic void rnd_ns();
    for (int i = 0; i < 9; i++) ns[i] = 8'($urandom);
    nst = 4'($urandom);
    ngr = 8'($urandom);
  endfunction

  function automatic void plan_ns();
    ns = '{8'd25, 8'd50, 8'd50, 8'd40, 8'd60, 8'd101, 8'd60, 8'd10, 8'd40};
    nst = 4'b0111;
    ngr = 8'd0;
  endfunction

  // One clock: check what the DUT shows now, then apply inputs for the next edge.
  task automatic cyc(input bit req, input bit rdy, input bit rs);
    @(negedge clk);
    chk("valid", txa.tx_valid, m_busy);
    chk("busy", busy_a, m_busy);
    chk("done", done_a, m_done);
    chk("seq", seq_a, m_seq);
    chk("ovr", ovr_a, m_ovr);
    if (m_busy) chk("data", txa.tx_data, m_frame[m_pos]);
    else if (m_dz) chk("data_rst", txa.tx_data, 0);
    rst = rs; sample_req = req; txa.tx_ready = rdy;
    sens = ns; {alert, hc, irr, fan} = nst; growth = ngr;
    m_done = 0;
    if (rs) begin
      m_busy = 0; m_pos = 0; m_seq = 0; m_ovr = 0; m_dz = 1;
    end else if (!m_busy) begin
      if (req) begin build(); m_busy = 1; m_pos = 0; m_dz = 0; end
    end else begin
      if (req && m_ovr < 255) m_ovr++;
      if (rdy) begin
        got.push_back(txa.tx_data);
        if (m_pos == 13) begin m_busy = 0; m_done = 1; m_seq = (m_seq + 1) % 256; end
        else m_pos++;
      end
    end
  endtask

  task automatic drain(input int p_stall, input int p_req, input bit rsens);
    for (int i = 0; i < 600 && (m_busy || m_done); i++) begin
      if (rsens) rnd_ns();
      cyc(m_busy && p_req > 0 && $urandom_range(p_req - 1) == 0,
          $urandom_range(99) >= p_stall, 1'b0);
    end
    chk("drain_to", busy_a, 0);
  endtask

  task automatic run_to(input int pos);
    for (int i = 0; i < 40 && m_pos != pos; i++) cyc(1'b0, 1'b1, 1'b0);
    chk("run_to", m_pos, pos);
  endtask

  task automatic cmp_frame(input string tag, input int exp [14]);
    for (int i = 0; i < 14; i++)
      chk($sformatf("%s_b%0d", tag, i), got.size() > i ? got[i] : -1, exp[i]);
    chk({tag, "_len"}, got.size(), 14);
  endtask

  initial begin
    int o0;
    g1 = '{8'hA5, 8'h00, 8'h19, 8'h32, 8'h32, 8'h28, 8'h3C, 8'h65, 8'h3C,
           8'h0A, 8'h28, 8'h07, 8'h00, 8'h45};
    g2 = g1; g2[1] = 8'h01; g2[13] = 8'h44;
    g3 = g1; g3[1] = 8'h02; g3[13] = 8'h43;
    txa.tx_ready = 1'b0; txb.tx_ready = 1'b1;
    plan_ns();
    sens = ns; {alert, hc, irr, fan} = nst; growth = ngr;
    repeat (3) @(posedge clk);

    // Reset state, then the reference frame with ready held high.
    cyc(1'b0, 1'b1, 1'b0);
    got.delete(); cyc(1'b1, 1'b1, 1'b0); drain(0, 0, 0);
    cmp_frame("f1", g1);
    chk("f1_seq", seq_a, 1);

    got.delete(); cyc(1'b1, 1'b1, 1'b0); drain(0, 0, 0);
    cmp_frame("f2", g2);
    chk("f2_seq", seq_a, 2);

    // Random ready stalls must not change the byte sequence.
    got.delete(); cyc(1'b1, 1'b1, 1'b0); drain(50, 0, 0);
    cmp_frame("f3", g3);

    // Request mid-frame is dropped; live input change does not reach the frame.
    got.delete(); cyc(1'b1, 1'b1, 1'b0);
    ns[0] = 8'd90;
    run_to(5);
    cyc(1'b1, 1'b1, 1'b0);
    drain(0, 0, 0);
    chk("ovr_one", ovr_a, 1);
    chk("temp_snap", got.size() > 2 ? got[2] : -1, 8'h19);

    // Trigger on the last handshake is dropped; one in the next cycle starts a frame.
    o0 = m_ovr;
    cyc(1'b1, 1'b1, 1'b0); run_to(13);
    cyc(1'b1, 1'b1, 1'b0);
    got.delete(); cyc(1'b1, 1'b1, 1'b0);
    chk("gap_done", done_a, 1);
    drain(0, 0, 0);
    chk("edge_ovr", ovr_a, o0 + 1);
    chk("gap_sync", got.size() > 0 ? got[0] : -1, 8'hA5);

    // Random frames with random stalls, requests and live input churn.
    for (int f = 0; f < 8; f++) begin
      rnd_ns(); cyc(1'b1, 1'b1, 1'b0);
      drain(40, 6, 1);
    end

    // Saturating overrun counter.
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) cyc(1'b1, 1'b0, 1'b0);
    drain(0, 0, 0);
    chk("ovr_sat", ovr_a, 255);

    // Reset in the middle of a frame.
    plan_ns();
    got.delete(); cyc(1'b1, 1'b1, 1'b0); run_to(7);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("rst_valid", txa.tx_valid, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_seq", seq_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_ovr", ovr_a, 0);
    got.delete(); cyc(1'b1, 1'b1, 1'b0); drain(0, 0, 0);
    chk("rst_f_sync", got.size() > 0 ? got[0] : -1, 8'hA5);
    chk("rst_f_seq", got.size() > 1 ? got[1] : -1, 8'h00);
    cmp_frame("f_rst", g1);

    // Periodic instance: frames start at cycles 50,100,150,200 after reset;
    // the request at 199 coincides with the tick and must count once.
    @(negedge clk); rst_b = 1'b0;
    for (int k = 1; k <= 220; k++) begin
      @(negedge clk);
      chk($sformatf("b_valid%0d", k), txb.tx_valid, (k >= 50 && k % 50 < 14));
      chk($sformatf("b_done%0d", k), done_b, (k >= 64 && k % 50 == 14));
      if (k % 50 == 0) chk($sformatf("b_sync%0d", k), txb.tx_data, 8'hA5);
      sample_req_b = (k == 199);
    end
    chk("b_ovr", ovr_b, 0);
    chk("b_seq", seq_b, 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/greenhouse_telemetry_tx.md
# greenhouse_telemetry_tx

Telemetry framer for the greenhouse controller. On a software request or a periodic tick it snapshots the nine 8-bit sensor readings, the actuator status bits and `growth_status`. It then streams them as a fixed 14-byte checksummed frame over a valid/ready byte interface. It sits between `GreenhouseMonitor` outputs and the serial/log link, as the sending end of the sensor-record path.

## Interface
- `SYNC_BYTE`, 8'hA5, first byte of every frame
- `PERIOD`, 1000, auto-trigger interval in clock cycles; 0 disables the periodic trigger
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `sample_req`  in  1  one-cycle request to send a frame
- `temperature`, `humidity`, `soil_moisture`, `co2_level`, `light_intensity`, `pressure`, `ph_level`, `pest_level`, `leaf_color`  in  8 each  live sensor values
- `fan`, `irrigation`, `humidity_control`, `alert`  in  1 each  live actuator/alert status
- `growth_status`  in  8  live growth status
- `tx_data`  out  8  frame byte
- `tx_valid`  out  1  `tx_data` is valid
- `tx_ready`  in  1  sink accepts the byte when `tx_valid && tx_ready`
- `busy`  out  1  frame in progress
- `frame_done`  out  1  one-cycle pulse after the last byte is accepted
- `frame_seq`  out  8  sequence number of the next frame
- `overrun_cnt`  out  8  saturating count of dropped triggers

## Operation
- States: IDLE and SEND; byte index `idx` runs 0..13.
- Trigger = `sample_req` OR periodic tick. If `sample_req` and the tick coincide, that counts as one trigger.
- IDLE with a trigger:
  - Snapshot all inputs into internal registers.
  - Go to SEND with `idx`=0.
- Frame byte order:
  - 0: `SYNC_BYTE`
  - 1: `frame_seq`
  - 2–10: temperature, humidity, soil_moisture, co2_level, light_intensity, pressure, ph_level, pest_level, leaf_color
  - 11: status = {4'b0, alert, humidity_control, irrigation, fan}
  - 12: growth_status
  - 13: checksum = (−Σ bytes 1..12) mod 256, so that bytes 1..13 sum to 0 mod 256
- Checksum arithmetic is 8-bit wrap. It is computed from the snapshot, never from live inputs.
- SEND:
  - `idx` advances on each handshake.
  - The handshake at `idx`=13 returns to IDLE, increments `frame_seq` (wraps 255→0) and pulses `frame_done`.
- A trigger while in SEND, or on the handshake cycle of `idx`=13, is dropped and increments `overrun_cnt`, which saturates at 255.
- Input changes during SEND do not affect the frame in flight.
- Periodic timer:
  - Free-running counter 0..PERIOD−1, counting regardless of state.
  - Tick fires when the counter equals PERIOD−1, then the counter wraps to 0.
- Reset values: `tx_valid`=0, `tx_data`=0, `busy`=0, `frame_done`=0, `frame_seq`=0, `overrun_cnt`=0, timer=0, state IDLE.
- Reset asserted mid-frame aborts the frame at that edge. No `frame_done` pulse is produced, and `frame_seq` returns to 0.

## Timing
- Trigger sampled at edge N → `tx_valid`=1 with `tx_data`=`SYNC_BYTE` and `busy`=1 from cycle N+1.
- `tx_data`/`tx_valid` are registered. They hold stable while `tx_valid && !tx_ready`, and `tx_valid` never drops mid-frame.
- With `tx_ready` held at 1, a frame takes 14 cycles. The last byte's handshake edge is M.
- Edge M leads to the following in cycle M+1:
  - `tx_valid`=0, `busy`=0, `frame_done`=1 for exactly one cycle
  - the incremented `frame_seq` is visible
- A trigger sampled in cycle M+1 is accepted. The minimum frame-to-frame gap is therefore one idle cycle.
- `tx_ready` stalls of any length are allowed. The timer keeps running during stalls.

## Structure
- Shared package `greenhouse_pkg`:
  - frame length constant (14)
  - byte-index constants (`IDX_SYNC`, `IDX_SEQ`, `IDX_STATUS`, `IDX_GROWTH`, `IDX_CSUM`)
  - state enum
  - status-byte bit positions
- Optional sub-module `gh_period_timer` holds the counter and the tick generation, including the `PERIOD`=0 disable.
- Snapshot registers and the byte mux stay in the top module.

## Test plan
- Reset, then one `sample_req` with `tx_ready`=1 and inputs temp 25, humidity 50, soil 50, co2 40, light 60, pressure 101, ph 60, pest 10, leaf 40, fan=irr=hc=1, alert=0, growth 0 → frame bytes A5,00,19,32,32,28,3C,65,3C,0A,28,07,00,45; `frame_done` one cycle later; `frame_seq`=1.
- Repeat with the same inputs → seq byte 01, checksum 44; `frame_seq`=2.
- Toggle `tx_ready` randomly during a frame → byte sequence identical to the first scenario, `tx_data` stable while stalled, no byte duplicated or skipped.
- Pulse `sample_req` at `idx`=5, change temperature to 90 during the frame → `overrun_cnt`=1, temperature byte stays 0x19; 256 further overruns → `overrun_cnt`=255.
- `PERIOD`=50, no `sample_req`, `tx_ready`=1 → frames start every 50 cycles, first `tx_valid` at cycle 50 after reset; simultaneous `sample_req`+tick → one frame, `overrun_cnt` unchanged.
- Assert `rst` at `idx`=7 → next cycle `tx_valid`=0, `busy`=0, `frame_seq`=0, no `frame_done`; the next frame starts with A5,00.
